// File: rtl/sram_fifo_spi_drain.sv
// Pulls 32-bit words from the SRAM FIFO and streams them MSB-first as bytes to the SPI slave TX port.
// Optional build macro SPI_DRAIN_SEQ_CHECK_EN adds a consecutive-word check that drives seq_err.
module sram_fifo_spi_drain #(
  parameter int CNT_W       = 16,
  parameter int MIN_AVAIL   = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer_start,
  input  logic [CNT_W-1:0] xfer_words,
  input  logic             xfer_abort,
  output logic             xfer_busy,
  output logic             xfer_done,
  output logic             xfer_err,
  output logic             fifo_re,
  input  logic [31:0]      fifo_data,
  input  logic             fifo_data_rdy,
  input  logic             fifo_busy,
  input  logic [21:0]      fifo_available,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             seq_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [21:0]      AVAIL_MIN = 22'(MIN_AVAIL);
  localparam logic [CNT_W-1:0] ONE_WORD  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             re_q, re_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             start_acc;
  logic             capture;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    pick_byte = w[31:24];
      2'd1:    pick_byte = w[23:16];
      2'd2:    pick_byte = w[15:8];
      default: pick_byte = w[7:0];
    endcase
  endfunction

  // TX handshake: a byte moves on any rising edge where tx_valid && tx_ready; while tx_valid
  // is high and not accepted, tx_byte and tx_valid hold. Each word is always sent in full.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tmo_d       = tmo_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    re_d        = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    start_acc   = 1'b0;
    capture     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer_start) begin
          start_acc = 1'b1;
          busy_d    = 1'b1;
          if (xfer_words == '0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (xfer_abort) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (!fifo_busy && fifo_available >= AVAIL_MIN) begin
          re_d    = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fifo_data_rdy) begin
          capture    = 1'b1;
          byte_idx_d = 2'd0;
          tx_byte_d  = pick_byte(fifo_data, 2'd0);
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else if (tmo_q >= TMO_LAST) begin
          tmo_d   = TMO_LIMIT;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (byte_idx_q == 2'd3) begin
            tx_valid_d  = 1'b0;
            remaining_d = remaining_q - ONE_WORD;
            if (remaining_q == ONE_WORD || xfer_abort) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_ARM;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_byte_d  = pick_byte(word_q, byte_idx_d);
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_acc) begin
      remaining_d = xfer_words;
      err_d       = 1'b0;
    end
    if (capture) begin
      word_d = fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      tmo_q       <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      re_q        <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tmo_q       <= tmo_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      re_q        <= re_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  assign xfer_busy = busy_q;
  assign xfer_done = done_q;
  assign xfer_err  = err_q;
  assign fifo_re   = re_q;
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;

`ifdef SPI_DRAIN_SEQ_CHECK_EN
  // word_q still holds the previous word at the moment a new one is captured.
  logic seq_err_q, seq_err_d;
  logic first_q, first_d;

  always_comb begin
    seq_err_d = seq_err_q;
    first_d   = first_q;
    if (start_acc) begin
      seq_err_d = 1'b0;
      first_d   = 1'b1;
    end else if (capture) begin
      first_d = 1'b0;
      if (!first_q && fifo_data != word_q + 32'd1) begin
        seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
      first_q   <= first_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_spi_drain.sv
// Bench for sram_fifo_spi_drain: behavioural FIFO + SPI sink model, expected byte queue, directed and random transfers.
module tb_sram_fifo_spi_drain;

  localparam int CNT_W       = 16;
  localparam int MIN_AVAIL   = 1;
  localparam int TIMEOUT_CYC = 16;

  // clock / reset / DUT
  logic             clk = 1'b0;
  logic             rst;
  logic             xfer_start;
  logic [CNT_W-1:0] xfer_words;
  logic             xfer_abort;
  logic             xfer_busy;
  logic             xfer_done;
  logic             xfer_err;
  logic             fifo_re;
  logic [31:0]      fifo_data;
  logic             fifo_data_rdy;
  logic             fifo_busy;
  logic [21:0]      fifo_available;
  logic [7:0]       tx_byte;
  logic             tx_valid;
  logic             tx_ready;
  logic             seq_err;

  sram_fifo_spi_drain #(
    .CNT_W(CNT_W),
    .MIN_AVAIL(MIN_AVAIL),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .xfer_start(xfer_start),
    .xfer_words(xfer_words),
    .xfer_abort(xfer_abort),
    .xfer_busy(xfer_busy),
    .xfer_done(xfer_done),
    .xfer_err(xfer_err),
    .fifo_re(fifo_re),
    .fifo_data(fifo_data),
    .fifo_data_rdy(fifo_data_rdy),
    .fifo_busy(fifo_busy),
    .fifo_available(fifo_available),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // scoreboard and model state
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] got_w[$];
  int          lat_cnt = 0;
  int          rdy_left = 0;
  bit          pending = 0;
  bit          mute = 0;
  bit          starve = 0;
  bit          busy_rand_en = 0;
  bit          abort_force = 0;
  int          ready_mode = 0;
  bit          hold_pending = 0;
  logic [7:0]  hold_byte = '0;
  int          re_cnt = 0;
  int          done_cnt = 0;
  int          acc_cnt = 0;
  int          abort_after = 0;
  int          re_tick = -1;
  int          err_tick = -1;
  int          exp_valid_tick = -1;
  int          rel_tick = 0;
  int          budget = 0;
  int          n_words = 0;
  logic [31:0] base_w;
  logic [31:0] cur_w;
  bit          prev_busy = 0;
  logic [21:0] prev_avail = '0;
  bit          prev_done = 0;
  bit          prev_tx_valid = 0;
  bit          prev_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected seq_err: any captured word that is not previous+1 within this transfer.
  function automatic logic seq_model();
`ifdef SPI_DRAIN_SEQ_CHECK_EN
    for (int i = 1; i < got_w.size(); i++) begin
      if (got_w[i] != got_w[i-1] + 32'd1) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  // One cycle: observe outputs at the falling edge, run the FIFO/sink models, drive inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (prev_done) begin
      check("done_one_cycle", xfer_done, 1'b0);
      check("busy_low_after_done", xfer_busy, 1'b0);
    end
    if (xfer_done) done_cnt++;
    prev_done = xfer_done;
    if (xfer_err && !prev_err) err_tick = cyc;
    prev_err = xfer_err;

    // FIFO read port: data valid for two cycles, lat cycles after the request
    if (rdy_left > 0) begin
      rdy_left--;
      fifo_data_rdy = 1'b1;
    end else if (pending) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        pending = 0;
        cur_w = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0;
        got_w.push_back(cur_w);
        exp_q.push_back(cur_w[31:24]);
        exp_q.push_back(cur_w[23:16]);
        exp_q.push_back(cur_w[15:8]);
        exp_q.push_back(cur_w[7:0]);
        fifo_data = cur_w;
        fifo_data_rdy = 1'b1;
        rdy_left = 1;
      end else begin
        fifo_data_rdy = 1'b0;
        fifo_data = $urandom;
      end
    end else begin
      fifo_data_rdy = 1'b0;
      fifo_data = $urandom;
    end

    if (fifo_re) begin
      re_cnt++;
      re_tick = cyc;
      check("re_legal", (prev_busy || prev_avail < 22'(MIN_AVAIL)), 1'b0);
      if (!mute) begin
        pending = 1;
        lat_cnt = $urandom_range(1, 3);
        exp_valid_tick = cyc + lat_cnt + 1;
      end
    end
    fifo_busy = pending || fifo_data_rdy || (busy_rand_en && $urandom_range(0, 3) == 0);
    fifo_available = starve ? 22'd0 : 22'(fifo_q.size());
    prev_busy = fifo_busy;
    prev_avail = fifo_available;

    // SPI byte sink
    if (tx_valid && !prev_tx_valid && exp_valid_tick >= 0)
      check("first_valid_latency", cyc, exp_valid_tick);
    if (hold_pending) begin
      check("tx_valid_held", tx_valid, 1'b1);
      check("tx_byte_held", tx_byte, hold_byte);
    end
    prev_tx_valid = tx_valid;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = !tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    hold_pending = 0;
    if (tx_valid) begin
      if (tx_ready) begin
        acc_cnt++;
        check("byte_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("tx_byte", tx_byte, exp_q.pop_front());
      end else begin
        hold_pending = 1;
        hold_byte = tx_byte;
      end
    end
    xfer_abort = (abort_after > 0 && acc_cnt >= abort_after) || abort_force;
  endtask

  task automatic begin_xfer(input int n);
    re_cnt = 0;
    done_cnt = 0;
    acc_cnt = 0;
    got_w.delete();
    exp_q.delete();
    err_tick = -1;
    re_tick = -1;
    xfer_words = n[CNT_W-1:0];
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    check("busy_after_start", xfer_busy, 1'b1);
  endtask

  task automatic finish_xfer(input int exp_re, input int exp_words, input logic exp_err);
    budget = 3000;
    while (done_cnt == 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("done_seen", done_cnt > 0, 1'b1);
    tick();
    check("done_count", done_cnt, 1);
    check("re_count", re_cnt, exp_re);
    check("bytes_sent", acc_cnt, 4 * exp_words);
    check("exp_q_drained", exp_q.size(), 0);
    check("xfer_err", xfer_err, exp_err);
    check("seq_err", seq_err, seq_model());
    abort_after = 0;
    abort_force = 0;
    xfer_abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, xfer_busy, 1'b0);
    check({tag, "_done"}, xfer_done, 1'b0);
    check({tag, "_err"}, xfer_err, 1'b0);
    check({tag, "_re"}, fifo_re, 1'b0);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_byte"}, tx_byte, 8'h00);
    check({tag, "_seq_err"}, seq_err, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    xfer_start = 1'b0;
    xfer_words = '0;
    xfer_abort = 1'b0;
    fifo_data = '0;
    fifo_data_rdy = 1'b0;
    fifo_busy = 1'b0;
    fifo_available = '0;
    tx_ready = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // two words back-to-back, sink always ready
    fifo_q = '{32'h11223344, 32'h55667788};
    ready_mode = 0;
    begin_xfer(2);
    finish_xfer(2, 2, 1'b0);

    // stalling sink
    fifo_q = '{32'hDEADBEEF};
    ready_mode = 1;
    begin_xfer(1);
    finish_xfer(1, 1, 1'b0);
    ready_mode = 0;

    // zero-word transfer completes at once
    begin_xfer(0);
    finish_xfer(0, 0, 1'b0);

    // starvation then availability
    fifo_q = '{32'hCAFEF00D};
    starve = 1;
    begin_xfer(1);
    repeat (50) tick();
    check("starve_no_re", re_cnt, 0);
    starve = 0;
    tick();
    rel_tick = cyc;
    finish_xfer(1, 1, 1'b0);
    check("re_after_available", re_tick - rel_tick, 1);

    // read timeout, then cleared by the next start
    fifo_q = '{32'h0BADF00D};
    mute = 1;
    begin_xfer(1);
    finish_xfer(1, 0, 1'b1);
    check("timeout_cycles", err_tick - re_tick, TIMEOUT_CYC);
    repeat (3) tick();
    check("err_sticky", xfer_err, 1'b1);
    mute = 0;
    fifo_q.delete();
    begin_xfer(0);
    finish_xfer(0, 0, 1'b0);

    // abort during word 2 finishes that word only
    for (int i = 0; i < 5; i++) fifo_q.push_back($urandom);
    abort_after = 5;
    begin_xfer(5);
    finish_xfer(2, 2, 1'b0);
    check("abort_words_left", fifo_q.size(), 3);
    fifo_q.delete();

    // start and abort together: accepted, no words moved
    fifo_q = '{32'h12345678};
    abort_force = 1;
    xfer_abort = 1'b1;
    begin_xfer(3);
    finish_xfer(0, 0, 1'b0);
    fifo_q.delete();

    // start while busy is ignored
    fifo_q = '{32'hA0A0A0A0, 32'h0B0B0B0B};
    begin_xfer(2);
    repeat (3) tick();
    xfer_words = 16'd9;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    finish_xfer(2, 2, 1'b0);

    // sequence check pattern 7, 8, 10
    fifo_q = '{32'd7, 32'd8, 32'd10};
    begin_xfer(3);
    finish_xfer(3, 3, 1'b0);
    fifo_q = '{32'hFFFFFFFF, 32'h0, 32'h1};
    begin_xfer(3);
    finish_xfer(3, 3, 1'b0);

    // reset in the middle of sending
    fifo_q = '{32'h01020304, 32'h05060708};
    begin_xfer(2);
    budget = 200;
    while (!tx_valid && budget > 0) begin
      tick();
      budget--;
    end
    check("reached_send", tx_valid, 1'b1);
    rst = 1'b1;
    hold_pending = 0;
    tick();
    check_all_zero("mid_send_reset");
    rst = 1'b0;
    repeat (5) tick();
    check_all_zero("after_send_reset");

    // reset while a read is outstanding; the late data must be ignored
    pending = 0;
    rdy_left = 0;
    fifo_q = '{32'h99887766};
    begin_xfer(1);
    budget = 200;
    while (!pending && budget > 0) begin
      tick();
      budget--;
    end
    check("read_outstanding", pending, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) begin
      tick();
      check("late_rdy_ignored_valid", tx_valid, 1'b0);
      check("late_rdy_ignored_busy", xfer_busy, 1'b0);
      check("late_rdy_ignored_done", xfer_done, 1'b0);
    end
    exp_q.delete();
    fifo_q.delete();

    // randomized transfers
    busy_rand_en = 1;
    ready_mode = 2;
    for (int t = 0; t < 10; t++) begin
      n_words = $urandom_range(1, 6);
      base_w = $urandom;
      for (int i = 0; i < n_words; i++)
        fifo_q.push_back(($urandom_range(0, 3) == 0) ? $urandom : base_w + i);
      begin_xfer(n_words);
      finish_xfer(n_words, n_words, 1'b0);
      check("fifo_emptied", fifo_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
